// File: rtl/init_sample_pipe_if.sv
// Handshake/data bundle for init_sample_pipe: pipeline controls and inputs in,
// last-stage data plus fill/priming/change status out.
interface init_sample_pipe_if #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 1,
   parameter int DEPTH    = 2
) ();
   localparam int DW = CHANNELS * WIDTH;
   localparam int FW = $clog2(DEPTH + 1);

   logic                advance;
   logic                flush;
   logic                in_valid;
   logic [DW-1:0]       in_data;
   logic [DW-1:0]       out_data;
   logic                out_valid;
   logic                primed;
   logic [FW-1:0]       fill_count;
   logic [CHANNELS-1:0] out_changed;

   modport master (
      output advance, flush, in_valid, in_data,
      input  out_data, out_valid, primed, fill_count, out_changed
   );

   modport slave (
      input  advance, flush, in_valid, in_data,
      output out_data, out_valid, primed, fill_count, out_changed
   );
endinterface

// File: rtl/init_sample_pipe.sv
// Multi-lane sampling pipeline whose every register is defined from the first
// reset edge; tracks per-stage valid, fill/priming and last-stage change pulses.
module init_sample_pipe #(
   parameter int               WIDTH    = 1,
   parameter int               CHANNELS = 1,
   parameter int               DEPTH    = 2,
   parameter logic [WIDTH-1:0] INIT     = '0
) (
   input logic               clock,
   input logic               reset,
   init_sample_pipe_if.slave bus
);
   localparam int            DW       = CHANNELS * WIDTH;
   localparam int            FW       = $clog2(DEPTH + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
   localparam logic [DW-1:0] INIT_ALL = {CHANNELS{INIT}};

   logic [DW-1:0]       r_data [DEPTH];
   logic [DEPTH-1:0]    r_valid;
   logic [FW-1:0]       r_fill;
   logic                r_primed;
   logic [CHANNELS-1:0] r_changed;

   logic [DW-1:0]       w_new_last;
   logic                w_new_last_valid;
   logic [FW-1:0]       w_fill_nxt;
   logic [CHANNELS-1:0] w_lane_diff;

   // Value the last stage takes on an advance; with one stage it is the input itself.
   generate
      if (DEPTH == 1) begin : g_single
         assign w_new_last       = bus.in_data;
         assign w_new_last_valid = bus.in_valid;
      end else begin : g_multi
         assign w_new_last       = r_data[DEPTH-2];
         assign w_new_last_valid = r_valid[DEPTH-2];
      end
   endgenerate

   assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + FW'(1);

   always_comb begin
      w_lane_diff = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_lane_diff[c] = (r_data[DEPTH-1][c*WIDTH +: WIDTH] != w_new_last[c*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset || bus.flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= INIT_ALL;
         end
         r_valid   <= '0;
         r_fill    <= '0;
         r_primed  <= 1'b0;
         r_changed <= '0;
      end else if (bus.advance) begin
         r_data[0]  <= bus.in_data;
         r_valid[0] <= bus.in_valid;
         for (int k = 1; k < DEPTH; k++) begin
            r_data[k]  <= r_data[k-1];
            r_valid[k] <= r_valid[k-1];
         end
         r_fill    <= w_fill_nxt;
         r_primed  <= (w_fill_nxt == FILL_MAX);
         // A change only counts between two valid samples.
         r_changed <= (r_valid[DEPTH-1] && w_new_last_valid) ? w_lane_diff : '0;
      end else begin
         r_changed <= '0;
      end
   end

   assign bus.out_data    = r_data[DEPTH-1];
   assign bus.out_valid   = r_valid[DEPTH-1];
   assign bus.primed      = r_primed;
   assign bus.fill_count  = r_fill;
   assign bus.out_changed = r_changed;
endmodule
